// File: rtl/sclk_generator.sv
// Serial clock burst generator with per-transaction half period, CPOL and CPHA.
// Edge strobes lead output_clk transitions by one clk cycle.
module sclk_generator #(
   parameter int HP_WIDTH  = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 trigger,
   input  logic                 abort,
   input  logic [HP_WIDTH-1:0]  half_period,
   input  logic [CNT_WIDTH-1:0] num_cycles,
   input  logic                 cpol,
   input  logic                 cpha,
   output logic                 output_clk,
   output logic                 busy,
   output logic                 done,
   output logic                 pre_leading_edge,
   output logic                 pre_trailing_edge,
   output logic                 sample_strobe,
   output logic                 shift_strobe
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t               state_q, state_d;
   logic [HP_WIDTH-1:0]  hp_q, hp_d;
   logic [CNT_WIDTH-1:0] n_q, n_d;
   logic                 cpol_q, cpol_d;
   logic                 cpha_q, cpha_d;
   logic [HP_WIDTH-1:0]  phase_q, phase_d;
   logic [CNT_WIDTH:0]   edges_q, edges_d;
   logic                 clk_out_q, clk_out_d;
   logic                 done_q, done_d;

   logic run;
   logic accept;
   logic last_phase;
   logic last_edge;
   logic lead;
   logic trail;

   assign run        = (state_q == RUN);
   assign accept     = (state_q == IDLE) && trigger && !abort;
   assign last_phase = (phase_q == hp_q - 1'b1);
   // edges_q is one bit wider than n_q, so 2N always fits
   assign last_edge  = ((edges_q + 1'b1) == {n_q, 1'b0});

   always_comb begin
      state_d   = state_q;
      hp_d      = hp_q;
      n_d       = n_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      phase_d   = phase_q;
      edges_d   = edges_q;
      clk_out_d = clk_out_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               hp_d      = (half_period == '0) ?
                           HP_WIDTH'(1) : half_period;
               n_d       = num_cycles;
               cpol_d    = cpol;
               cpha_d    = cpha;
               clk_out_d = cpol;
               phase_d   = '0;
               edges_d   = '0;
               if (num_cycles != '0) begin
                  state_d = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d   = IDLE;
               clk_out_d = cpol_q;
            end else if (last_phase) begin
               phase_d   = '0;
               clk_out_d = ~clk_out_q;
               edges_d   = edges_q + 1'b1;
               if (last_edge) begin
                  state_d   = IDLE;
                  done_d    = 1'b1;
                  clk_out_d = cpol_q;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         hp_q      <= '0;
         n_q       <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         phase_q   <= '0;
         edges_q   <= '0;
         clk_out_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hp_q      <= hp_d;
         n_q       <= n_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         phase_q   <= phase_d;
         edges_q   <= edges_d;
         clk_out_q <= clk_out_d;
         done_q    <= done_d;
      end
   end

   assign lead  = run && last_phase && (clk_out_q == cpol_q);
   assign trail = run && last_phase && (clk_out_q != cpol_q);

   assign output_clk        = clk_out_q;
   assign busy              = run;
   assign done              = done_q;
   assign pre_leading_edge  = lead;
   assign pre_trailing_edge = trail;
   assign sample_strobe     = cpha_q ? trail : lead;
   assign shift_strobe      = cpha_q ? lead : trail;

endmodule
